mem_refill_ctrl: RTL and testbench
==================================

MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all ports below are sampled or driven on the rising edge of clk_i.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse; requests the initial fill.
- update_mem_i  in  1  refill request level from the timing core; a rising edge is a request.
- points_per_line_i  in  10  last point address per memory; words per memory = value+1.
- num_mems_i  in  3  memories filled per refill; 0 is treated as 1.
- s_data_i  in  17  stream word.
- s_valid_i  in  1  stream word valid.
- s_ready_o  out  1  stream ready.
- waddr_o  out  11  memory write address.
- wdata_o  out  17  memory write data.
- we_o  out  1  memory write enable.
- memory_selector_o  out  3  target memory index.
- mem_updated_o  out  1  one-cycle pulse at refill completion.
- busy_o  out  1  refill in progress.
- overrun_o  out  1  sticky: a request was lost.
- clr_overrun_i  in  1  clears overrun_o.

Function
REQ-003 The block SHALL implement the FSM states IDLE, FILL and DONE.
REQ-004 In IDLE, a request SHALL move the FSM to FILL on the next cycle; a request is start_i=1, a rising edge of update_mem_i, or pending=1.
- On that transition the block SHALL latch points_per_line_i and num_mems_i, and set the address and selector counters to 0.
REQ-005 s_ready_o SHALL equal 1 exactly when the state is FILL.
REQ-006 A stream handshake SHALL be a cycle with s_valid_i=1 and s_ready_o=1. On the following cycle:
- we_o=1.
- wdata_o = the accepted word.
- waddr_o and memory_selector_o = the counter values at the handshake.
- Write latency SHALL be 1 cycle.
REQ-007 After each handshake the address counter SHALL increment. When it equals the latched points_per_line, it SHALL wrap to 0 and the selector SHALL increment.
REQ-008 The handshake on address = latched ppl and selector = latched num_mems-1 SHALL be the last one. The FSM SHALL then move to DONE, and s_ready_o SHALL be 0 on the next cycle.
REQ-009 In DONE, mem_updated_o SHALL be 1 for exactly one cycle, coincident with we_o of the last word. The FSM SHALL then return to IDLE.
REQ-010 When s_valid_i=0 in FILL, the block SHALL hold its state and counters and keep we_o=0. There is no timeout.
REQ-011 busy_o SHALL equal 1 in FILL and DONE.
REQ-012 A request arriving while busy_o=1 SHALL set pending. A second request while pending=1 SHALL set overrun_o instead, and pending SHALL stay 1.
REQ-013 Pending SHALL clear when IDLE consumes it. start_i and an update_mem_i edge in the same IDLE cycle SHALL count as one request.
REQ-014 clr_overrun_i SHALL clear overrun_o. If clr_overrun_i and a new overrun occur in the same cycle, overrun_o SHALL end at 1.
REQ-015 Config input changes during FILL SHALL have no effect until the next refill.
REQ-016 The address counter SHALL be 11 bits. The maximum ppl of 1023 gives addresses 0..1023 without overflow.
REQ-017 A ppl of 0 SHALL produce one word per memory.

Reset
REQ-018 While rst_i=1 the block SHALL set:
- state = IDLE; counters = 0; pending = 0.
- update_mem_i edge register = 0.
- s_ready_o = 0; we_o = 0; waddr_o = 0; wdata_o = 0; memory_selector_o = 0.
- mem_updated_o = 0; busy_o = 0; overrun_o = 0.
REQ-019 A reset during FILL SHALL abandon the partial refill, with no mem_updated_o pulse and no further writes.
REQ-020 A level-high update_mem_i present when reset releases SHALL NOT count as a request.

Structure
REQ-021 The state encoding (IDLE=2'b00, FILL=2'b01, DONE=2'b10) and the widths ADDR_W=11, DATA_W=17 and SEL_W=3 SHALL live in the shared timing-core package.
REQ-022 The block SHALL instantiate the existing edgeDetector sub-module for update_mem_i and SHALL contain no other sub-modules.

Verification
REQ-023 The bench SHALL cover these scenarios:
- ppl=3, mems=2, start pulse, s_valid_i held 1: 8 writes; (sel,addr) = (0,0..3) then (1,0..3); mem_updated pulse with the 8th we_o; busy_o high for 9 cycles.
- ppl=0, mems=0: exactly 1 write at (0,0), then mem_updated.
- ppl=3, mems=1, s_valid_i toggling 1,0,1,0...: writes only on the cycle after each valid; waddr_o has no gaps.
- update_mem_i rises during FILL, then again: pending serviced with a new FILL right after DONE→IDLE; overrun_o=1 until clr_overrun_i.
- rst_i asserted after 2 of 4 words: all outputs 0 the next cycle, no mem_updated; the next start gives a full fill from (0,0).
- update_mem_i high through reset release: no refill starts.

Source files
------------

// File: rtl/mem_refill_ctrl_pkg.sv
// Shared timing-core definitions for the memory refill controller:
// state encoding, datapath widths and the memory-count helper.
package mem_refill_ctrl_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 17;
   localparam int SEL_W  = 3;
   localparam int PPL_W  = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FILL = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // A memory count of zero still means one memory gets filled.
   function automatic logic [SEL_W-1:0] last_sel_f(input logic [SEL_W-1:0] num_mems);
      last_sel_f = (num_mems == 3'd0) ? 3'd0 : num_mems - 3'd1;
   endfunction

endpackage

// File: rtl/mem_refill_ctrl_edge_detector.sv
// Rising-edge detector for a level request. The first sampled level after
// reset only arms the detector, so a level already high at release is ignored.
module edgeDetector (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic rise_o
);

   logic prev;
   logic armed;

   // Previous-level and arm registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev  <= 1'b0;
         armed <= 1'b0;
      end else begin
         prev  <= level_i;
         armed <= 1'b1;
      end
   end

   assign rise_o = armed & level_i & ~prev;

endmodule

// File: rtl/mem_refill_ctrl.sv
// Refill controller: streams words into a bank of memories, one line per
// memory, on a start pulse or a rising refill request from the timing core.
module mem_refill_ctrl
   import mem_refill_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              update_mem_i,
   input  logic [PPL_W-1:0]  points_per_line_i,
   input  logic [SEL_W-1:0]  num_mems_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              we_o,
   output logic [SEL_W-1:0]  memory_selector_o,
   output logic              mem_updated_o,
   output logic              busy_o,
   output logic              overrun_o,
   input  logic              clr_overrun_i
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [SEL_W-1:0]  sel, sel_nxt;
   logic [PPL_W-1:0]  ppl, ppl_nxt;
   logic [SEL_W-1:0]  last_sel, last_sel_nxt;
   logic              pending, pending_nxt;
   logic              overrun, overrun_nxt;
   logic              upd_rise;
   logic              new_req;
   logic              handshake;
   logic              line_end;
   logic              last_word;
   logic              overrun_set;

   edgeDetector u_upd_edge (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (update_mem_i),
      .rise_o  (upd_rise)
   );

   // Next-state, counter, pending and overrun logic.
   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr;
      sel_nxt      = sel;
      ppl_nxt      = ppl;
      last_sel_nxt = last_sel;
      pending_nxt  = pending;
      overrun_set  = 1'b0;

      new_req   = start_i | upd_rise;
      handshake = (state == ST_FILL) & s_valid_i;
      line_end  = (addr == {1'b0, ppl});
      last_word = handshake & line_end & (sel == last_sel);

      case (state)
         ST_IDLE: begin
            if (new_req | pending) begin
               state_nxt    = ST_FILL;
               ppl_nxt      = points_per_line_i;
               last_sel_nxt = last_sel_f(num_mems_i);
               addr_nxt     = 11'd0;
               sel_nxt      = 3'd0;
               pending_nxt  = 1'b0;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (handshake) begin
               if (line_end) begin
                  addr_nxt = 11'd0;
                  sel_nxt  = sel + 3'd1;
               end else begin
                  addr_nxt = addr + 11'd1;
               end
               if (last_word) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_FILL;
               end
            end else begin
               state_nxt = ST_FILL;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Requests while busy queue one refill; anything beyond that is lost.
      if ((state != ST_IDLE) && new_req) begin
         if (pending) begin
            overrun_set = 1'b1;
         end else begin
            pending_nxt = 1'b1;
         end
      end else begin
         overrun_set = 1'b0;
      end

      overrun_nxt = (overrun & ~clr_overrun_i) | overrun_set;
   end

   // Control state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         addr     <= 11'd0;
         sel      <= 3'd0;
         ppl      <= 10'd0;
         last_sel <= 3'd0;
         pending  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         sel      <= sel_nxt;
         ppl      <= ppl_nxt;
         last_sel <= last_sel_nxt;
         pending  <= pending_nxt;
         overrun  <= overrun_nxt;
      end
   end

   // Memory write port, one cycle behind the accepted stream word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_o              <= 1'b0;
         waddr_o           <= 11'd0;
         wdata_o           <= 17'd0;
         memory_selector_o <= 3'd0;
      end else begin
         we_o <= handshake;
         if (handshake) begin
            waddr_o           <= addr;
            wdata_o           <= s_data_i;
            memory_selector_o <= sel;
         end else begin
            waddr_o           <= waddr_o;
            wdata_o           <= wdata_o;
            memory_selector_o <= memory_selector_o;
         end
      end
   end

   assign s_ready_o     = (state == ST_FILL);
   assign busy_o        = (state == ST_FILL) | (state == ST_DONE);
   assign mem_updated_o = (state == ST_DONE);
   assign overrun_o     = overrun;

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Self-checking bench for mem_refill_ctrl: directed scenarios plus randomized
// fills compared against an expected write list built from nested loops.
module tb_mem_refill_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        update_mem_i;
   logic [9:0]  points_per_line_i;
   logic [2:0]  num_mems_i;
   logic [16:0] s_data_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic [10:0] waddr_o;
   logic [16:0] wdata_o;
   logic        we_o;
   logic [2:0]  memory_selector_o;
   logic        mem_updated_o;
   logic        busy_o;
   logic        overrun_o;
   logic        clr_overrun_i;

   int n_pass  = 0;
   int n_total = 0;

   mem_refill_ctrl dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .start_i           (start_i),
      .update_mem_i      (update_mem_i),
      .points_per_line_i (points_per_line_i),
      .num_mems_i        (num_mems_i),
      .s_data_i          (s_data_i),
      .s_valid_i         (s_valid_i),
      .s_ready_o         (s_ready_o),
      .waddr_o           (waddr_o),
      .wdata_o           (wdata_o),
      .we_o              (we_o),
      .memory_selector_o (memory_selector_o),
      .mem_updated_o     (mem_updated_o),
      .busy_o            (busy_o),
      .overrun_o         (overrun_o),
      .clr_overrun_i     (clr_overrun_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; update_mem_i = 1'b0; points_per_line_i = 10'd0;
      num_mems_i = 3'd0; s_data_i = 17'd0; s_valid_i = 1'b0; clr_overrun_i = 1'b0;
      step(); step();
      n_total++;
      if ({s_ready_o, we_o, waddr_o, wdata_o, memory_selector_o, mem_updated_o, busy_o, overrun_o} !== 36'd0)
         $display("FAIL reset_outputs: got %h want 0", {s_ready_o, we_o, waddr_o, wdata_o,
                  memory_selector_o, mem_updated_o, busy_o, overrun_o});
      else n_pass++;
      rst_i = 1'b0;
      step();
   endtask

   // mode 0: valid held high, 1: valid toggles 1,0,1,0..., 2: random valid.
   task automatic do_fill(input int ppl, input int mems, input int mode, input string tag);
      int          exp_sel[$];
      int          exp_addr[$];
      int          nm, total, idx, busy_cnt, we_cnt, cyc;
      logic        hs, last, v, exp_rdy, exp_busy;
      logic [30:0] hs_word;
      nm = (mems == 0) ? 1 : mems;
      for (int s = 0; s < nm; s++)
         for (int a = 0; a <= ppl; a++) begin
            exp_sel.push_back(s);
            exp_addr.push_back(a);
         end
      total = exp_sel.size();
      s_valid_i = 1'b0;
      points_per_line_i = 10'(ppl);
      num_mems_i = 3'(mems);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      idx = 0; hs = 1'b0; last = 1'b0; busy_cnt = 0; we_cnt = 0; cyc = 0; hs_word = 31'd0;
      forever begin
         exp_rdy  = (idx < total);
         exp_busy = exp_rdy | last;
         n_total++;
         if ({we_o, mem_updated_o, s_ready_o, busy_o} !== {hs, last, exp_rdy, exp_busy})
            $display("FAIL %s_ctrl cyc %0d: got we/upd/rdy/busy=%b want %b", tag, cyc,
                     {we_o, mem_updated_o, s_ready_o, busy_o}, {hs, last, exp_rdy, exp_busy});
         else n_pass++;
         if (hs) begin
            n_total++;
            if ({memory_selector_o, waddr_o, wdata_o} !== hs_word)
               $display("FAIL %s_write cyc %0d: got sel/addr/data=%h want %h", tag, cyc,
                        {memory_selector_o, waddr_o, wdata_o}, hs_word);
            else n_pass++;
         end
         if (busy_o) busy_cnt++;
         if (we_o) we_cnt++;
         if (last || cyc >= 5000) break;
         case (mode)
            0:       v = 1'b1;
            1:       v = ((cyc % 2) == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         s_valid_i = v;
         s_data_i = 17'($urandom);
         hs = v && (idx < total);
         last = 1'b0;
         if (hs) begin
            hs_word = {3'(exp_sel[idx]), 11'(exp_addr[idx]), s_data_i};
            last = (idx == total - 1);
            idx++;
         end
         // Config changes mid-fill must be ignored.
         points_per_line_i = 10'($urandom);
         num_mems_i = 3'($urandom);
         step();
         cyc++;
      end
      n_total++;
      if (!last) $display("FAIL %s_timeout: got %0d words want %0d", tag, idx, total);
      else n_pass++;
      n_total++;
      if (we_cnt != total) $display("FAIL %s_write_count: got %0d want %0d", tag, we_cnt, total);
      else n_pass++;
      if (mode == 0) begin
         n_total++;
         if (busy_cnt != total + 1)
            $display("FAIL %s_busy_cycles: got %0d want %0d", tag, busy_cnt, total + 1);
         else n_pass++;
      end
      s_valid_i = 1'b0;
      step();
      n_total++;
      if ({busy_o, s_ready_o, we_o, mem_updated_o} !== 4'b0000)
         $display("FAIL %s_idle_after: got %b want 0000", tag, {busy_o, s_ready_o, we_o, mem_updated_o});
      else n_pass++;
   endtask

   // Feed valid words until mem_updated_o; checks the number of writes seen.
   task automatic drain(input int exp_words, input string tag);
      int   n;
      logic seen;
      n = 0; seen = 1'b0;
      s_valid_i = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         s_data_i = 17'($urandom);
         step();
         if (we_o) n++;
         if (mem_updated_o) begin
            seen = 1'b1;
            break;
         end
      end
      s_valid_i = 1'b0;
      n_total++;
      if (!seen || n != exp_words)
         $display("FAIL %s_drain: got done=%0d words=%0d want done=1 words=%0d", tag, seen, n, exp_words);
      else n_pass++;
   endtask

   task automatic test_pending_overrun();
      points_per_line_i = 10'd3; num_mems_i = 3'd1; s_valid_i = 1'b0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      update_mem_i = 1'b1; step();
      update_mem_i = 1'b0; step();
      n_total++;
      if (overrun_o !== 1'b0) $display("FAIL pend_first_req: got overrun=%b want 0", overrun_o);
      else n_pass++;
      update_mem_i = 1'b1; step();
      update_mem_i = 1'b0;
      n_total++;
      if (overrun_o !== 1'b1) $display("FAIL pend_second_req: got overrun=%b want 1", overrun_o);
      else n_pass++;
      drain(4, "pend_fill1");
      step();
      n_total++;
      if ({busy_o, s_ready_o} !== 2'b00) $display("FAIL pend_idle: got busy/rdy=%b want 00", {busy_o, s_ready_o});
      else n_pass++;
      step();
      n_total++;
      if ({s_ready_o, overrun_o} !== 2'b11)
         $display("FAIL pend_refill_start: got rdy/overrun=%b want 11", {s_ready_o, overrun_o});
      else n_pass++;
      clr_overrun_i = 1'b1; step();
      clr_overrun_i = 1'b0;
      n_total++;
      if (overrun_o !== 1'b0) $display("FAIL pend_clear: got overrun=%b want 0", overrun_o);
      else n_pass++;
      update_mem_i = 1'b1; step();
      update_mem_i = 1'b0; step();
      update_mem_i = 1'b1; clr_overrun_i = 1'b1; step();
      update_mem_i = 1'b0; clr_overrun_i = 1'b0;
      n_total++;
      if (overrun_o !== 1'b1) $display("FAIL pend_clr_collide: got overrun=%b want 1", overrun_o);
      else n_pass++;
      drain(4, "pend_fill2");
      step(); step();
      n_total++;
      if (s_ready_o !== 1'b1) $display("FAIL pend_third_start: got rdy=%b want 1", s_ready_o);
      else n_pass++;
      drain(4, "pend_fill3");
      step();
      clr_overrun_i = 1'b1; step();
      clr_overrun_i = 1'b0;
      n_total++;
      if ({overrun_o, busy_o} !== 2'b00) $display("FAIL pend_final: got overrun/busy=%b want 00", {overrun_o, busy_o});
      else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      logic stray;
      points_per_line_i = 10'd3; num_mems_i = 3'd1;
      start_i = 1'b1; step();
      start_i = 1'b0;
      s_valid_i = 1'b1; s_data_i = 17'h1a5a5; step();
      s_data_i = 17'h0c3c3; step();
      n_total++;
      if ({we_o, waddr_o, wdata_o} !== {1'b1, 11'd1, 17'h0c3c3})
         $display("FAIL rstmid_second_word: got %h want %h", {we_o, waddr_o, wdata_o}, {1'b1, 11'd1, 17'h0c3c3});
      else n_pass++;
      rst_i = 1'b1; step();
      n_total++;
      if ({s_ready_o, we_o, waddr_o, wdata_o, memory_selector_o, mem_updated_o, busy_o, overrun_o} !== 36'd0)
         $display("FAIL rstmid_outputs: got %h want 0", {s_ready_o, we_o, waddr_o, wdata_o,
                  memory_selector_o, mem_updated_o, busy_o, overrun_o});
      else n_pass++;
      rst_i = 1'b0;
      stray = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         stray = stray | we_o | mem_updated_o | busy_o;
      end
      n_total++;
      if (stray !== 1'b0) $display("FAIL rstmid_no_activity: got %b want 0", stray);
      else n_pass++;
      s_valid_i = 1'b0;
      do_fill(3, 1, 0, "rstmid_refill");
   endtask

   task automatic test_update_through_reset();
      logic started;
      rst_i = 1'b1; update_mem_i = 1'b1;
      step(); step();
      rst_i = 1'b0;
      started = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         started = started | busy_o | s_ready_o;
      end
      n_total++;
      if (started !== 1'b0) $display("FAIL level_at_release: got started=%b want 0", started);
      else n_pass++;
      update_mem_i = 1'b0;
      step();
   endtask

   task automatic test_random_fills();
      for (int i = 0; i < 6; i++)
         do_fill(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 2, "random");
   endtask

   initial begin
      test_reset();
      do_fill(3, 2, 0, "basic");
      do_fill(0, 0, 0, "minimal");
      do_fill(3, 1, 1, "toggle");
      test_pending_overrun();
      test_reset_mid_fill();
      test_update_through_reset();
      test_random_fills();
      do_fill(1023, 1, 0, "max_ppl");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
